// File: rtl/multi_channel_tick_gen.sv
// Multi-channel programmable tick generator: NUM_CH independent dividers, each
// producing either a one-cycle strobe or a 50% square wave from clk_in.
module multi_channel_tick_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int DEFAULT_DIV  = 500000,
    parameter int DEFAULT_MODE = 0,
    parameter int CH_W         = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] tick_out,
    output logic              cfg_err
);

    logic ch_invalid;
    logic cfg_err_reg;

    // When every cfg_ch encoding maps to a real channel, no write can be rejected.
    generate
        if ((2 ** CH_W) > NUM_CH) begin : g_range_chk
            assign ch_invalid = (cfg_ch >= CH_W'(NUM_CH));
        end else begin : g_full_range
            assign ch_invalid = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we && ch_invalid;
        end
    end

    assign cfg_err = cfg_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] div_reg;
            logic             mode_reg;
            logic             tick_reg;
            logic             cfg_hit;
            logic             at_last;

            assign cfg_hit = cfg_we && (cfg_ch == CH_IDX);
            // Only meaningful when div_reg != 0; the idle branch below covers zero.
            assign at_last = (count_reg == (div_reg - CNT_W'(1)));

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                    div_reg   <= CNT_W'(DEFAULT_DIV);
                    mode_reg  <= (DEFAULT_MODE != 0);
                    tick_reg  <= 1'b0;
                end else begin
                    // A write lands even when sync_clr overrides the restart.
                    if (cfg_hit) begin
                        div_reg  <= cfg_div;
                        mode_reg <= cfg_mode;
                    end

                    if (sync_clr || cfg_hit || (div_reg == '0)) begin
                        count_reg <= '0;
                        tick_reg  <= 1'b0;
                    end else if (!en[gi]) begin
                        if (!mode_reg) begin
                            tick_reg <= 1'b0;
                        end
                    end else if (at_last) begin
                        count_reg <= '0;
                        tick_reg  <= mode_reg ? ~tick_reg : 1'b1;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                        if (!mode_reg) begin
                            tick_reg <= 1'b0;
                        end
                    end
                end
            end

            assign tick_out[gi] = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_tick_gen.sv
// Self-checking bench for multi_channel_tick_gen: directed scenarios plus random
// traffic, compared each cycle against an elapsed-cycle reference model.
module tb_multi_channel_tick_gen;

    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 16;
    localparam int DEFAULT_DIV  = 5;
    localparam int DEFAULT_MODE = 0;
    localparam int CH_W         = 3;

    logic              clk_in;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] tick_out;
    logic              cfg_err;

    multi_channel_tick_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .DEFAULT_MODE(DEFAULT_MODE),
        .CH_W        (CH_W)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_mode(cfg_mode),
        .tick_out(tick_out),
        .cfg_err (cfg_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: per channel, number of enabled cycles since the last restart.
    int                n_assert;
    int                n_fail;
    int                elapsed [NUM_CH];
    int                m_div   [NUM_CH];
    bit                m_mode  [NUM_CH];
    logic [NUM_CH-1:0] exp_tick;
    logic              exp_err;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            elapsed[i] = 0;
            m_div[i]   = DEFAULT_DIV;
            m_mode[i]  = (DEFAULT_MODE != 0);
        end
        exp_tick = '0;
        exp_err  = 1'b0;
    endtask

    task automatic model_edge();
        exp_err = cfg_we && (int'(cfg_ch) >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            bit hit;
            hit = cfg_we && (int'(cfg_ch) == i);
            if (hit) begin
                m_div[i]  = int'(cfg_div);
                m_mode[i] = cfg_mode;
            end
            if (sync_clr || hit || m_div[i] == 0) begin
                elapsed[i]  = 0;
                exp_tick[i] = 1'b0;
            end else begin
                if (en[i]) elapsed[i]++;
                if (m_mode[i])
                    exp_tick[i] = ((elapsed[i] / m_div[i]) % 2) == 1;
                else
                    exp_tick[i] = en[i] && ((elapsed[i] % m_div[i]) == 0);
            end
        end
    endtask

    task automatic check(input string tag);
        n_assert++;
        assert (tick_out === exp_tick) else begin
            n_fail++;
            $error("FAIL %s tick_out observed=%b expected=%b", tag, tick_out, exp_tick);
        end
        n_assert++;
        assert (cfg_err === exp_err) else begin
            n_fail++;
            $error("FAIL %s cfg_err observed=%b expected=%b", tag, cfg_err, exp_err);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_in);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check(tag);
        $display("t=%0t %s en=%b clr=%b we=%b ch=%0d div=%0d mode=%b tick=%b err=%b",
                 $time, tag, en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_mode, tick_out, cfg_err);
    endtask

    task automatic cfg_write(input int ch, input int div, input bit mode, input string tag);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(div);
        cfg_mode = mode;
        step(tag);
        cfg_we   = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = '1;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_mode = 1'b0;
        model_reset();

        step("reset");
        step("reset");
        rst_n = 1'b1;

        // Default divisor 5, pulse: high on cycles 5, 10, 15 after release.
        for (int k = 1; k <= 16; k++) begin
            step("default");
            n_assert++;
            assert (tick_out === ((k % 5 == 0) ? 4'hF : 4'h0)) else begin
                n_fail++;
                $error("FAIL default_k%0d tick_out observed=%b expected=%b", k, tick_out,
                       ((k % 5 == 0) ? 4'hF : 4'h0));
            end
        end

        cfg_write(1, 3, 1'b1, "cfg_sq3");
        repeat (13) step("square");

        cfg_write(2, 4, 1'b0, "cfg_p4");
        repeat (2) step("ch2_run");
        en[2] = 1'b0;
        repeat (7) step("ch2_off");
        en[2] = 1'b1;
        repeat (6) step("ch2_on");

        repeat (2) step("pre_clr");
        sync_clr = 1'b1;
        step("sync_clr");
        sync_clr = 1'b0;
        repeat (12) step("post_clr");

        cfg_write(3, 0, 1'b0, "cfg_div0");
        repeat (4) step("div0");
        cfg_write(3, 1, 1'b0, "cfg_div1");
        repeat (4) step("div1");

        sync_clr = 1'b1;
        cfg_write(0, 2, 1'b1, "clr_and_cfg");
        sync_clr = 1'b0;
        repeat (6) step("after_clr_cfg");

        cfg_write(5, 7, 1'b1, "cfg_bad");
        repeat (3) step("after_bad");

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            en       = NUM_CH'($urandom_range(0, 15) | (($urandom_range(0, 3) != 0) ? 4'hF : 4'h0));
            sync_clr = ($urandom_range(0, 39) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 7));
            cfg_div  = CNT_W'($urandom_range(0, 7));
            cfg_mode = 1'($urandom_range(0, 1));
            step("random");
        end
        en       = '1;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;

        // Async reset while tick_out[0] and cfg_err are both high.
        cfg_write(0, 1, 1'b0, "cfg_ch0_div1");
        cfg_write(6, 3, 1'b0, "cfg_bad2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        $display("t=%0t async_rst tick=%b err=%b", $time, tick_out, cfg_err);
        step("in_reset");
        rst_n = 1'b1;
        repeat (11) step("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
